adc_capture: RTL and testbench
==============================

# adc_capture

Downstream consumer of the board top's ADC AXI-stream outputs, on the ZCU216 build. On a trigger it writes a programmable number of optionally decimated ADC stream beats into one BRAM write port. That BRAM is read by the host through the bram-to-host path. Control comes from local-bus registers; status returns to the same registers.

## Interface
Parameters:
- DATAWIDTH, 64, ADC AXIS beat width (matches ADC_AXIS_DATAWIDTH)
- ADDRWIDTH, 13, BRAM word-address width (depth 2^ADDRWIDTH)
- LENWIDTH, 16, capture-length register width
- DECWIDTH, 8, decimation register width

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  ADC-domain clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATAWIDTH  ADC sample beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  always 1 out of reset; block never backpressures
- arm  in  1  single-cycle pulse: start a new capture
- abort  in  1  single-cycle pulse: stop and return to IDLE
- trig  in  1  capture trigger, level-sampled while ARMED
- len  in  LENWIDTH  number of words to write; latched on arm
- decim  in  DECWIDTH  keep 1 of every decim+1 valid beats; latched on arm
- bram_addr  out  ADDRWIDTH  write word address
- bram_din  out  DATAWIDTH  write data
- bram_we  out  1  write strobe
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  sticky completion flag
- wr_count  out  LENWIDTH  words written in the current or last capture

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE or DONE, arm=1: latch len and decim; clear wr_count, done, address and decimation phase; go to ARMED.
- ARMED, trig=1: go to CAPTURE.
  - If s_axis_tvalid is high in the same cycle, that beat is decimation phase 0 and is written as word 0.
  - If the latched len=0: go directly to DONE, with no writes.
- CAPTURE: every valid beat advances the decimation phase counter 0..decim.
  - A beat at phase 0 is written at bram_addr, then the address increments.
  - wr_count increments per write.
  - When wr_count reaches len, go to DONE and set done=1.
- Beats arriving outside the capture window (IDLE, ARMED without trig, DONE) are accepted and discarded.
- Address wrap: bram_addr wraps modulo 2^ADDRWIDTH. When len exceeds the depth, later words overwrite earlier ones; wr_count still counts to len.
- abort in any state: go to IDLE next cycle, drop any write not yet issued, leave done=0. wr_count keeps its value.
- arm in ARMED or CAPTURE: ignored.
- abort and arm in the same cycle: abort wins.
- Reset mid-capture: all state clears immediately. Partial BRAM contents are undefined.

## Timing
- Reset values: s_axis_tready=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, done=0, wr_count=0, state=IDLE. tready goes to 1 on the first clock after rstn deasserts.
- Write latency: an accepted beat appears on bram_din/bram_we one cycle later, with registered outputs.
- Writes with decim=0 are back-to-back: one per cycle at full stream rate.
- wr_count and bram_addr update in the same cycle as bram_we.
- done rises in the same cycle as the last bram_we. done stays high until the next arm or reset.
- busy falls in the same cycle that done rises.
- trig has no latency: it is sampled in the cycle it occurs while ARMED.

## Structure
- Shared header adc_capture_pkg holds:
  - the state encoding (2-bit localparams for IDLE, ARMED, CAPTURE, DONE)
  - default widths
  - the decimation-counter width rule
- One sub-module, sample_decim: a phase counter with load/clear, a keep output and a wrap at decim. It can be reused on the DAC-side monitor tap.
- Everything else stays in a single always block plus a registered output stage.

## Test plan
- Basic: decim=0, len=8, continuous valid data 0,1,2..., trig 3 cycles after arm → 8 writes at addresses 0..7 with consecutive data, starting 1 cycle after trig. done=1 and wr_count=8 on the last write.
- Decimation: decim=2, len=4, counting data starting at 0 on the trig cycle → written data 0,3,6,9 at addresses 0..3.
- Gaps: tvalid toggling 1/0, decim=1, len=3 → only valid beats advance the phase. The write pattern matches a software model beat for beat.
- Wrap: ADDRWIDTH=3, len=10 → addresses 0..7, 0, 1. done is asserted after the 10th write.
- Edge cases:
  - len=0 → trig gives done with no bram_we.
  - arm during CAPTURE → ignored.
  - abort at wr_count=2 → IDLE, done=0, no further writes.
- Reset: rstn asserted mid-capture → every output returns to its reset value asynchronously. A fresh arm afterwards captures normally.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg
// Shared definitions for the ADC capture path and its helpers:
//   - 2-bit capture state encoding (IDLE, ARMED, CAPTURE, DONE)
//   - default widths for the capture block parameters
//   - decimCntWidth(): width of the decimation phase counter
package adc_capture_pkg;

  typedef logic [1:0] cap_state_t;

  localparam cap_state_t ST_IDLE    = 2'd0;
  localparam cap_state_t ST_ARMED   = 2'd1;
  localparam cap_state_t ST_CAPTURE = 2'd2;
  localparam cap_state_t ST_DONE    = 2'd3;

  localparam int DEF_DATAWIDTH = 64;
  localparam int DEF_ADDRWIDTH = 13;
  localparam int DEF_LENWIDTH  = 16;
  localparam int DEF_DECWIDTH  = 8;

  // The phase counter runs 0..decim. The largest decim a DECWIDTH-bit
  // register can hold fits in DECWIDTH bits, so the counter matches it.
  // The width never drops below one bit.
  function automatic int decimCntWidth(input int decWidth);
    return (decWidth < 1) ? 1 : decWidth;
  endfunction

endpackage

// File: rtl/sample_decim.sv
// sample_decim
// Decimation phase counter. It keeps 1 of every decim+1 beats that it is
// told to advance on. The same block serves the DAC-side monitor tap.
// Ports:
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   i_load    in   latch i_decim and restart at phase 0
//   i_decim   in   decimation value; the phase wraps after reaching it
//   i_advance in   one beat consumed; step the phase
//   o_keep    out  the current beat is at phase 0 and should be kept
module sample_decim
  import adc_capture_pkg::*;
#(
  parameter int DECWIDTH = DEF_DECWIDTH
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_load,
  input  logic [DECWIDTH-1:0] i_decim,
  input  logic                i_advance,
  output logic                o_keep
);

  localparam int CW = decimCntWidth(DECWIDTH);

  logic [CW-1:0] r_phase;
  logic [CW-1:0] r_decim;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= '0;
      r_decim <= '0;
    end else if (i_load) begin
      r_phase <= '0;
      r_decim <= CW'(i_decim);
    end else if (i_advance) begin
      r_phase <= (r_phase == r_decim) ? '0 : r_phase + CW'(1);
    end
  end

  assign o_keep = (r_phase == '0);

endmodule

// File: rtl/adc_capture.sv
// adc_capture
// Writes a programmable number of optionally decimated ADC stream beats
// into one BRAM write port once a trigger arrives.
// Ports:
//   clk, rstn          ADC-domain clock, asynchronous active-low reset
//   s_axis_tdata/valid ADC beat stream
//   s_axis_tready      out; 1 out of reset, the block never backpressures
//   arm, abort         single-cycle control pulses; abort wins over arm
//   trig               capture trigger, level-sampled while armed
//   len, decim         capture length and decimation, latched on arm
//   bram_addr/din/we   registered BRAM write port, one cycle after the beat
//   busy               armed or capturing
//   done               sticky completion flag, cleared by arm or reset
//   wr_count           words written in the current or last capture
module adc_capture
  import adc_capture_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int LENWIDTH  = DEF_LENWIDTH,
  parameter int DECWIDTH  = DEF_DECWIDTH
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATAWIDTH-1:0] s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig,
  input  logic [LENWIDTH-1:0]  len,
  input  logic [DECWIDTH-1:0]  decim,
  output logic [ADDRWIDTH-1:0] bram_addr,
  output logic [DATAWIDTH-1:0] bram_din,
  output logic                 bram_we,
  output logic                 busy,
  output logic                 done,
  output logic [LENWIDTH-1:0]  wr_count
);

  cap_state_t           r_state;
  logic [LENWIDTH-1:0]  r_len;
  logic [LENWIDTH-1:0]  r_wrCount;
  logic [ADDRWIDTH-1:0] r_addrNext;
  logic [ADDRWIDTH-1:0] r_bramAddr;
  logic [DATAWIDTH-1:0] r_bramDin;
  logic                 r_bramWe;
  logic                 r_done;
  logic                 r_tready;

  logic                 w_idleLike;
  logic                 w_armLoad;
  logic                 w_trigStart;
  logic                 w_capBeat;
  logic                 w_keep;
  logic                 w_write;
  logic [LENWIDTH-1:0]  w_wrCountNext;

  assign w_idleLike  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_armLoad   = arm && !abort && w_idleLike;
  assign w_trigStart = (r_state == ST_ARMED) && trig && !abort;

  // The trigger-cycle beat already belongs to the capture window, so it is
  // counted as phase 0. A zero-length capture never opens the window.
  assign w_capBeat = s_axis_tvalid && !abort &&
                     ((w_trigStart && (r_len != '0)) || (r_state == ST_CAPTURE));

  assign w_write       = w_capBeat && w_keep;
  assign w_wrCountNext = r_wrCount + LENWIDTH'(1);

  sample_decim #(
    .DECWIDTH (DECWIDTH)
  ) u_decim (
    .clk       (clk),
    .rstn      (rstn),
    .i_load    (w_armLoad),
    .i_decim   (decim),
    .i_advance (w_capBeat),
    .o_keep    (w_keep)
  );

  // Control and write port share one block. The write path at the bottom
  // overrides the state transition when it issues the final word, so done
  // and the last write strobe land in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_wrCount  <= '0;
      r_addrNext <= '0;
      r_bramAddr <= '0;
      r_bramDin  <= '0;
      r_bramWe   <= 1'b0;
      r_done     <= 1'b0;
      r_tready   <= 1'b0;
    end else begin
      r_tready <= 1'b1;
      r_bramWe <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              r_len      <= len;
              r_wrCount  <= '0;
              r_done     <= 1'b0;
              r_addrNext <= '0;
              r_bramAddr <= '0;
              r_state    <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (trig) begin
              if (r_len == '0) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_CAPTURE;
              end
            end
          end
          default: begin
          end
        endcase
        if (w_write) begin
          r_bramWe   <= 1'b1;
          r_bramDin  <= s_axis_tdata;
          r_bramAddr <= r_addrNext;
          r_addrNext <= r_addrNext + ADDRWIDTH'(1);
          r_wrCount  <= w_wrCountNext;
          if (w_wrCountNext == r_len) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign s_axis_tready = r_tready;
  assign bram_addr     = r_bramAddr;
  assign bram_din      = r_bramDin;
  assign bram_we       = r_bramWe;
  assign done          = r_done;
  assign wr_count      = r_wrCount;
  assign busy          = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);

endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture
// Self-checking bench for adc_capture. A reference model derives the
// expected BRAM write list from the beat stream (count valid beats from the
// trigger, keep every (decim+1)-th, stop at len or abort, address modulo
// depth). That list is compared with the writes observed on the DUT port.
module tb_adc_capture;

  localparam int DW   = 64;
  localparam int AW   = 3;
  localparam int LW   = 16;
  localparam int DCW  = 8;
  localparam int NCYC = 200;

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          arm;
  logic          abort;
  logic          trig;
  logic [LW-1:0] len;
  logic [DCW-1:0] decim;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic          busy;
  logic          done;
  logic [LW-1:0] wr_count;

  int errors = 0;
  int checks = 0;

  bit            stVld [NCYC];
  logic [DW-1:0] stDat [NCYC];

  int            obsCyc[$];
  int            obsAddr[$];
  logic [DW-1:0] obsData[$];
  int            obsCnt[$];
  bit            obsDone[$];
  bit            obsBusy[$];

  int            expCyc[$];
  int            expAddr[$];
  logic [DW-1:0] expData[$];
  bit            expDone;

  int            preWe;
  int            postWe;
  bit            timedOut;
  logic          finDone;
  logic          finBusy;
  logic [LW-1:0] finCount;

  adc_capture #(
    .DATAWIDTH (DW),
    .ADDRWIDTH (AW),
    .LENWIDTH  (LW),
    .DECWIDTH  (DCW)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .arm           (arm),
    .abort         (abort),
    .trig          (trig),
    .len           (len),
    .decim         (decim),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_we       (bram_we),
    .busy          (busy),
    .done          (done),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat stream from the trigger cycle on: vmode 0 = always valid,
  // 1 = valid on even cycles, 2 = random valid.
  task automatic fillStim(input int vmode, input bit countData);
    for (int i = 0; i < NCYC; i++) begin
      if (vmode == 0)      stVld[i] = 1'b1;
      else if (vmode == 1) stVld[i] = (i % 2 == 0);
      else                 stVld[i] = 1'($urandom_range(0, 1));
      stDat[i] = countData ? DW'(i) : {$urandom, $urandom};
    end
  endtask

  task automatic model(input int d, input int l, input int abortAt);
    int k;
    int nW;
    k = 0;
    nW = 0;
    expCyc.delete();
    expAddr.delete();
    expData.delete();
    expDone = (l == 0);
    if (l != 0) begin
      for (int i = 0; i < NCYC; i++) begin
        if (i == abortAt) break;
        if (stVld[i]) begin
          if (k % (d + 1) == 0) begin
            expCyc.push_back(i);
            expAddr.push_back(nW % (1 << AW));
            expData.push_back(stDat[i]);
            nW++;
            if (nW == l) begin
              expDone = 1'b1;
              break;
            end
          end
          k++;
        end
      end
    end
  endtask

  // Arms with (d, l), waits preTrig cycles with junk beats, then plays the
  // stored stream with trig in cycle 0. armAt/abortAt pulse arm (with junk
  // len/decim) or abort in that stream cycle; -1 disables them.
  task automatic runCapture(input int d, input int l, input int preTrig,
                            input int armAt, input int abortAt);
    obsCyc.delete(); obsAddr.delete(); obsData.delete();
    obsCnt.delete(); obsDone.delete(); obsBusy.delete();
    s_axis_tvalid = 1'b0;
    arm   = 1'b1;
    len   = LW'(l);
    decim = DCW'(d);
    tick();
    arm   = 1'b0;
    len   = LW'($urandom);
    decim = DCW'($urandom);
    preWe = 0;
    for (int p = 0; p < preTrig; p++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom, $urandom};
      tick();
      if (bram_we) preWe++;
    end
    timedOut = 1'b1;
    for (int i = 0; i < NCYC; i++) begin
      trig          = (i == 0);
      s_axis_tvalid = stVld[i];
      s_axis_tdata  = stDat[i];
      arm           = (i == armAt);
      abort         = (i == abortAt);
      tick();
      if (bram_we === 1'b1) begin
        obsCyc.push_back(i);
        obsAddr.push_back(int'(bram_addr));
        obsData.push_back(bram_din);
        obsCnt.push_back(int'(wr_count));
        obsDone.push_back(done);
        obsBusy.push_back(busy);
      end
      if (done === 1'b1 || i == abortAt) begin
        timedOut = 1'b0;
        break;
      end
    end
    trig  = 1'b0;
    arm   = 1'b0;
    abort = 1'b0;
    postWe = 0;
    for (int p = 0; p < 4; p++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom, $urandom};
      tick();
      if (bram_we) postWe++;
    end
    s_axis_tvalid = 1'b0;
    finDone  = done;
    finBusy  = busy;
    finCount = wr_count;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    arm = 1'b0; abort = 1'b0; trig = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; len = '0; decim = '0;
    #3;
    checks++;
    if (s_axis_tready !== 1'b0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || wr_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset.values got tready=%b we=%b addr=%0d din=%h busy=%b done=%b cnt=%0d exp all zero",
               s_axis_tready, bram_we, bram_addr, bram_din, busy, done, wr_count);
    end
    #9;
    rstn = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset.treadyBeforeEdge got=%b exp=0", s_axis_tready);
    end
    tick();
    checks++;
    if (s_axis_tready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset.afterEdge got tready=%b busy=%b done=%b exp tready=1 busy=0 done=0",
               s_axis_tready, busy, done);
    end
  endtask

  task automatic test_basic();
    bit lastW;
    fillStim(0, 1);
    model(0, 8, -1);
    runCapture(0, 8, 2, -1, -1);
    checks++;
    if (timedOut !== 1'b0 || obsCyc.size() != expCyc.size() || obsCyc.size() != 8) begin
      errors++;
      $display("[TB] FAIL basic.writes got=%0d timeout=%b exp=8", obsCyc.size(), timedOut);
    end
    for (int k = 0; k < obsCyc.size() && k < expCyc.size(); k++) begin
      lastW = (k == expCyc.size() - 1) && expDone;
      checks++;
      if (obsCyc[k] !== expCyc[k] || obsAddr[k] !== expAddr[k] || obsData[k] !== expData[k] ||
          obsAddr[k] !== k || obsData[k] !== DW'(k) || obsCnt[k] !== k + 1 ||
          obsDone[k] !== lastW || obsBusy[k] !== !lastW) begin
        errors++;
        $display("[TB] FAIL basic.write[%0d] got cyc=%0d addr=%0d data=%h cnt=%0d done=%b busy=%b exp cyc=%0d addr=%0d data=%h cnt=%0d done=%b",
                 k, obsCyc[k], obsAddr[k], obsData[k], obsCnt[k], obsDone[k], obsBusy[k],
                 expCyc[k], expAddr[k], expData[k], k + 1, lastW);
      end
    end
    checks++;
    if (preWe !== 0 || postWe !== 0 || finDone !== 1'b1 || finBusy !== 1'b0 || finCount !== LW'(8)) begin
      errors++;
      $display("[TB] FAIL basic.final got preWe=%0d postWe=%0d done=%b busy=%b cnt=%0d exp 0 0 1 0 8",
               preWe, postWe, finDone, finBusy, finCount);
    end
  endtask

  task automatic test_decimation();
    bit lastW;
    fillStim(0, 1);
    model(2, 4, -1);
    runCapture(2, 4, 1, -1, -1);
    checks++;
    if (timedOut !== 1'b0 || obsCyc.size() != expCyc.size() || obsCyc.size() != 4) begin
      errors++;
      $display("[TB] FAIL decim.writes got=%0d timeout=%b exp=4", obsCyc.size(), timedOut);
    end
    for (int k = 0; k < obsCyc.size() && k < expCyc.size(); k++) begin
      lastW = (k == expCyc.size() - 1) && expDone;
      checks++;
      if (obsCyc[k] !== expCyc[k] || obsAddr[k] !== expAddr[k] || obsData[k] !== expData[k] ||
          obsData[k] !== DW'(3 * k) || obsCnt[k] !== k + 1 || obsDone[k] !== lastW) begin
        errors++;
        $display("[TB] FAIL decim.write[%0d] got cyc=%0d addr=%0d data=%h cnt=%0d done=%b exp cyc=%0d addr=%0d data=%0d cnt=%0d done=%b",
                 k, obsCyc[k], obsAddr[k], obsData[k], obsCnt[k], obsDone[k],
                 expCyc[k], expAddr[k], 3 * k, k + 1, lastW);
      end
    end
    checks++;
    if (preWe !== 0 || postWe !== 0 || finDone !== 1'b1 || finCount !== LW'(4)) begin
      errors++;
      $display("[TB] FAIL decim.final got preWe=%0d postWe=%0d done=%b cnt=%0d exp 0 0 1 4",
               preWe, postWe, finDone, finCount);
    end
  endtask

  task automatic test_gaps();
    bit lastW;
    fillStim(1, 1);
    model(1, 3, -1);
    runCapture(1, 3, 0, -1, -1);
    checks++;
    if (timedOut !== 1'b0 || obsCyc.size() != expCyc.size() || obsCyc.size() != 3) begin
      errors++;
      $display("[TB] FAIL gaps.writes got=%0d timeout=%b exp=3", obsCyc.size(), timedOut);
    end
    for (int k = 0; k < obsCyc.size() && k < expCyc.size(); k++) begin
      lastW = (k == expCyc.size() - 1) && expDone;
      checks++;
      if (obsCyc[k] !== expCyc[k] || obsCyc[k] !== 4 * k || obsAddr[k] !== expAddr[k] ||
          obsData[k] !== expData[k] || obsCnt[k] !== k + 1 || obsDone[k] !== lastW) begin
        errors++;
        $display("[TB] FAIL gaps.write[%0d] got cyc=%0d addr=%0d data=%h cnt=%0d done=%b exp cyc=%0d addr=%0d data=%h cnt=%0d done=%b",
                 k, obsCyc[k], obsAddr[k], obsData[k], obsCnt[k], obsDone[k],
                 expCyc[k], expAddr[k], expData[k], k + 1, lastW);
      end
    end
  endtask

  task automatic test_wrap();
    bit lastW;
    fillStim(0, 0);
    model(0, 10, -1);
    runCapture(0, 10, 1, -1, -1);
    checks++;
    if (timedOut !== 1'b0 || obsCyc.size() != expCyc.size() || obsCyc.size() != 10) begin
      errors++;
      $display("[TB] FAIL wrap.writes got=%0d timeout=%b exp=10", obsCyc.size(), timedOut);
    end
    for (int k = 0; k < obsCyc.size() && k < expCyc.size(); k++) begin
      lastW = (k == expCyc.size() - 1) && expDone;
      checks++;
      if (obsCyc[k] !== expCyc[k] || obsAddr[k] !== expAddr[k] || obsAddr[k] !== (k % 8) ||
          obsData[k] !== expData[k] || obsCnt[k] !== k + 1 || obsDone[k] !== lastW) begin
        errors++;
        $display("[TB] FAIL wrap.write[%0d] got cyc=%0d addr=%0d data=%h cnt=%0d done=%b exp cyc=%0d addr=%0d data=%h cnt=%0d done=%b",
                 k, obsCyc[k], obsAddr[k], obsData[k], obsCnt[k], obsDone[k],
                 expCyc[k], k % 8, expData[k], k + 1, lastW);
      end
    end
    checks++;
    if (finDone !== 1'b1 || finCount !== LW'(10) || postWe !== 0) begin
      errors++;
      $display("[TB] FAIL wrap.final got done=%b cnt=%0d postWe=%0d exp 1 10 0", finDone, finCount, postWe);
    end
  endtask

  task automatic test_len_zero();
    fillStim(0, 0);
    model(0, 0, -1);
    runCapture(0, 0, 1, -1, -1);
    checks++;
    if (timedOut !== 1'b0 || obsCyc.size() != 0 || expCyc.size() != 0 || finDone !== expDone ||
        finBusy !== 1'b0 || finCount !== '0 || preWe !== 0 || postWe !== 0) begin
      errors++;
      $display("[TB] FAIL len0.result got writes=%0d timeout=%b done=%b busy=%b cnt=%0d postWe=%0d exp writes=0 done=1 busy=0 cnt=0",
               obsCyc.size(), timedOut, finDone, finBusy, finCount, postWe);
    end
  endtask

  task automatic test_arm_during_capture();
    bit lastW;
    fillStim(0, 0);
    model(0, 6, -1);
    runCapture(0, 6, 1, 2, -1);
    checks++;
    if (timedOut !== 1'b0 || obsCyc.size() != expCyc.size()) begin
      errors++;
      $display("[TB] FAIL armIgnored.writes got=%0d timeout=%b exp=%0d", obsCyc.size(), timedOut, expCyc.size());
    end
    for (int k = 0; k < obsCyc.size() && k < expCyc.size(); k++) begin
      lastW = (k == expCyc.size() - 1) && expDone;
      checks++;
      if (obsCyc[k] !== expCyc[k] || obsAddr[k] !== expAddr[k] || obsData[k] !== expData[k] ||
          obsCnt[k] !== k + 1 || obsDone[k] !== lastW) begin
        errors++;
        $display("[TB] FAIL armIgnored.write[%0d] got cyc=%0d addr=%0d cnt=%0d done=%b exp cyc=%0d addr=%0d cnt=%0d done=%b",
                 k, obsCyc[k], obsAddr[k], obsCnt[k], obsDone[k], expCyc[k], expAddr[k], k + 1, lastW);
      end
    end
    checks++;
    if (finDone !== 1'b1 || finCount !== LW'(6)) begin
      errors++;
      $display("[TB] FAIL armIgnored.final got done=%b cnt=%0d exp 1 6", finDone, finCount);
    end
  endtask

  task automatic test_abort();
    fillStim(0, 0);
    model(0, 8, 2);
    runCapture(0, 8, 1, -1, 2);
    checks++;
    if (timedOut !== 1'b0 || obsCyc.size() != expCyc.size() || obsCyc.size() != 2) begin
      errors++;
      $display("[TB] FAIL abort.writes got=%0d timeout=%b exp=2", obsCyc.size(), timedOut);
    end
    checks++;
    if (finDone !== 1'b0 || finBusy !== 1'b0 || finCount !== LW'(2) || postWe !== 0 || expDone !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort.final got done=%b busy=%b cnt=%0d postWe=%0d exp 0 0 2 0",
               finDone, finBusy, finCount, postWe);
    end
  endtask

  task automatic test_random();
    bit lastW;
    int d;
    int l;
    for (int r = 0; r < 3; r++) begin
      d = $urandom_range(0, 3);
      l = $urandom_range(1, 12);
      fillStim(2, 0);
      model(d, l, -1);
      runCapture(d, l, $urandom_range(0, 3), -1, -1);
      checks++;
      if (timedOut !== 1'b0 || obsCyc.size() != expCyc.size()) begin
        errors++;
        $display("[TB] FAIL random%0d.writes got=%0d timeout=%b exp=%0d (decim=%0d len=%0d)",
                 r, obsCyc.size(), timedOut, expCyc.size(), d, l);
      end
      for (int k = 0; k < obsCyc.size() && k < expCyc.size(); k++) begin
        lastW = (k == expCyc.size() - 1) && expDone;
        checks++;
        if (obsCyc[k] !== expCyc[k] || obsAddr[k] !== expAddr[k] || obsData[k] !== expData[k] ||
            obsCnt[k] !== k + 1 || obsDone[k] !== lastW || obsBusy[k] !== !lastW) begin
          errors++;
          $display("[TB] FAIL random%0d.write[%0d] got cyc=%0d addr=%0d data=%h cnt=%0d done=%b exp cyc=%0d addr=%0d data=%h cnt=%0d done=%b",
                   r, k, obsCyc[k], obsAddr[k], obsData[k], obsCnt[k], obsDone[k],
                   expCyc[k], expAddr[k], expData[k], k + 1, lastW);
        end
      end
      checks++;
      if (preWe !== 0 || postWe !== 0 || finDone !== 1'b1 || finCount !== LW'(l)) begin
        errors++;
        $display("[TB] FAIL random%0d.final got preWe=%0d postWe=%0d done=%b cnt=%0d exp 0 0 1 %0d",
                 r, preWe, postWe, finDone, finCount, l);
      end
    end
  endtask

  task automatic test_reset_mid_capture();
    s_axis_tvalid = 1'b0;
    arm = 1'b1; len = LW'(8); decim = '0;
    tick();
    arm = 1'b0;
    trig = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = DW'(64'hA5);
    tick();
    trig = 1'b0; s_axis_tdata = DW'(64'h5A);
    tick();
    checks++;
    if (bram_we !== 1'b1 || wr_count !== LW'(2) || busy !== 1'b1 || bram_din !== DW'(64'h5A)) begin
      errors++;
      $display("[TB] FAIL midReset.pre got we=%b cnt=%0d busy=%b din=%h exp 1 2 1 5a",
               bram_we, wr_count, busy, bram_din);
    end
    rstn = 1'b0;
    #2;
    checks++;
    if (s_axis_tready !== 1'b0 || bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || wr_count !== '0) begin
      errors++;
      $display("[TB] FAIL midReset.async got tready=%b we=%b addr=%0d din=%h busy=%b done=%b cnt=%0d exp all zero",
               s_axis_tready, bram_we, bram_addr, bram_din, busy, done, wr_count);
    end
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #3;
    rstn = 1'b1;
    tick();
    checks++;
    if (s_axis_tready !== 1'b1 || bram_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midReset.release got tready=%b we=%b busy=%b exp 1 0 0", s_axis_tready, bram_we, busy);
    end
    fillStim(0, 0);
    model(0, 5, -1);
    runCapture(0, 5, 1, -1, -1);
    checks++;
    if (timedOut !== 1'b0 || obsCyc.size() != expCyc.size() || finDone !== 1'b1 || finCount !== LW'(5)) begin
      errors++;
      $display("[TB] FAIL midReset.fresh got writes=%0d timeout=%b done=%b cnt=%0d exp writes=%0d done=1 cnt=5",
               obsCyc.size(), timedOut, finDone, finCount, expCyc.size());
    end
    for (int k = 0; k < obsCyc.size() && k < expCyc.size(); k++) begin
      checks++;
      if (obsCyc[k] !== expCyc[k] || obsAddr[k] !== expAddr[k] || obsData[k] !== expData[k]) begin
        errors++;
        $display("[TB] FAIL midReset.write[%0d] got cyc=%0d addr=%0d data=%h exp cyc=%0d addr=%0d data=%h",
                 k, obsCyc[k], obsAddr[k], obsData[k], expCyc[k], expAddr[k], expData[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decimation();
    test_gaps();
    test_wrap();
    test_len_zero();
    test_arm_during_capture();
    test_abort();
    test_random();
    test_reset_mid_capture();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
